prog_launch_ctrl: RTL and testbench

Sequencer between the host/loader side and the CPU core. It accepts a program-launch request (program 1 = reciprocal, 2 = 16/8 divide, 3 = square root) and selects the matching start PC. It pulses CpuStart for a fixed window and waits for the CPU's Ack, then reports completion. It also arbitrates the single data-memory write port: the host owns it while idle, the CPU owns it while a program runs.

---
 rtl/prog_launch_ctrl.sv | 153 +++++++++++++++
 tb/tb_prog_launch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_launch_ctrl.sv
// Program launch sequencer with data-memory write-port arbitration.
// Optional watchdog on the RUN state is enabled by defining WDOG_EN.
module prog_launch_ctrl #(
  parameter int PC_W      = 10,
  parameter int PROG1_PC  = 0,
  parameter int PROG2_PC  = 128,
  parameter int PROG3_PC  = 256,
  parameter int START_CYC = 2,
  parameter int TO_W      = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            ReqValid,
  input  logic [1:0]      ReqProg,
  output logic            ReqReady,
  input  logic            HostWe,
  input  logic [7:0]      HostAddr,
  input  logic [7:0]      HostWdata,
  input  logic            CpuWe,
  input  logic [7:0]      CpuAddr,
  input  logic [7:0]      CpuWdata,
  output logic            MemWe,
  output logic [7:0]      MemAddr,
  output logic [7:0]      MemWdata,
  output logic            CpuStart,
  output logic [PC_W-1:0] StartPC,
  input  logic            CpuAck,
  output logic            Busy,
  output logic            Done,
  output logic [1:0]      DoneProg,
  output logic            Err,
  output logic            HostConflict
);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_RUN, S_FIN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_prog;
  logic [PC_W-1:0] r_start_pc;
  logic [3:0]      r_start_cnt;
  logic            r_ack_low;
  logic            r_err;

  logic w_idle;
  logic w_cpu_own;
  logic w_accept;
  logic w_illegal;
  logic w_ack_edge;
  logic w_start_last;
  logic w_timeout;

  assign w_idle       = (r_state == S_IDLE);
  assign w_cpu_own    = (r_state == S_START) || (r_state == S_RUN);
  assign w_accept     = w_idle && ReqValid && (ReqProg != 2'd0);
  assign w_illegal    = w_idle && ReqValid && (ReqProg == 2'd0);
  assign w_ack_edge   = CpuAck && r_ack_low;
  assign w_start_last = (r_start_cnt == 4'(START_CYC - 1));

`ifdef WDOG_EN
  logic [TO_W-1:0] r_wdog;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wdog <= '0;
    end else if (r_state != S_RUN) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_RUN) && (&r_wdog) && !w_ack_edge;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_START;
      S_START: if (w_start_last) w_next = S_RUN;
      S_RUN: begin
        if (w_ack_edge)     w_next = S_FIN;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Ack must be seen low during this launch before a high level counts.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_prog      <= 2'd0;
      r_start_pc  <= PC_W'(PROG1_PC);
      r_start_cnt <= 4'd0;
      r_ack_low   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_illegal || w_timeout;
      if (w_accept) begin
        r_prog <= ReqProg;
        unique case (ReqProg)
          2'd1:    r_start_pc <= PC_W'(PROG1_PC);
          2'd2:    r_start_pc <= PC_W'(PROG2_PC);
          default: r_start_pc <= PC_W'(PROG3_PC);
        endcase
      end
      if ((r_state == S_START) && !w_start_last) begin
        r_start_cnt <= r_start_cnt + 4'd1;
      end else begin
        r_start_cnt <= 4'd0;
      end
      if (w_cpu_own) begin
        r_ack_low <= r_ack_low || !CpuAck;
      end else begin
        r_ack_low <= 1'b0;
      end
    end
  end

  always_comb begin
    ReqReady     = w_idle;
    CpuStart     = (r_state == S_START);
    Busy         = w_cpu_own;
    Done         = (r_state == S_FIN);
    DoneProg     = (r_state == S_FIN) ? r_prog : 2'd0;
    Err          = r_err;
    StartPC      = r_start_pc;
    HostConflict = w_cpu_own && HostWe;
    if (w_cpu_own) begin
      MemWe    = CpuWe;
      MemAddr  = CpuAddr;
      MemWdata = CpuWdata;
    end else begin
      MemWe    = HostWe;
      MemAddr  = HostAddr;
      MemWdata = HostWdata;
    end
  end

endmodule

// File: tb/tb_prog_launch_ctrl.sv
// Scoreboard bench for prog_launch_ctrl: stimulus queues expected
// events, a negedge monitor pops and compares them.
module tb_prog_launch_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       ReqValid;
  logic [1:0] ReqProg;
  logic       ReqReady;
  logic       HostWe;
  logic [7:0] HostAddr, HostWdata;
  logic       CpuWe;
  logic [7:0] CpuAddr, CpuWdata;
  logic       MemWe;
  logic [7:0] MemAddr, MemWdata;
  logic       CpuStart;
  logic [9:0] StartPC;
  logic       CpuAck;
  logic       Busy, Done, Err, HostConflict;
  logic [1:0] DoneProg;

  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;
  localparam int K_MEM  = 3;
  localparam int K_CONF = 4;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  prog_launch_ctrl #(.TO_W(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqProg(ReqProg), .ReqReady(ReqReady),
    .HostWe(HostWe), .HostAddr(HostAddr), .HostWdata(HostWdata),
    .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWdata(CpuWdata),
    .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .CpuStart(CpuStart), .StartPC(StartPC), .CpuAck(CpuAck),
    .Busy(Busy), .Done(Done), .DoneProg(DoneProg), .Err(Err),
    .HostConflict(HostConflict)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic mon_pop(input int kind, input int val);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d val %0d expected none",
               kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        bad++;
        $display("FAIL event: got kind %0d val %0h expected kind %0d val %0h",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (Done)         mon_pop(K_DONE, int'(DoneProg));
      if (Err)          mon_pop(K_ERR, 0);
      if (MemWe)        mon_pop(K_MEM, {16'd0, MemAddr, MemWdata});
      if (HostConflict) mon_pop(K_CONF, 0);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] p);
    ReqValid = 1'b1;
    ReqProg  = p;
    tick();
    ReqValid = 1'b0;
    ReqProg  = 2'd0;
  endtask

  task automatic finish_ack(input int p);
    CpuAck = 1'b1;
    expect_ev(K_DONE, p);
    tick();
    tick();
    CpuAck = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; ReqValid = 1'b0; ReqProg = 2'd0;
    HostWe = 1'b0; HostAddr = 8'd0; HostWdata = 8'd0;
    CpuWe = 1'b0; CpuAddr = 8'd0; CpuWdata = 8'd0;
    CpuAck = 1'b0;
    tick();
    tick();
    chk("rst_cpustart", int'(CpuStart), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_startpc", int'(StartPC), 0);
    chk("rst_ready", int'(ReqReady), 1);
    chk("rst_doneprog", int'(DoneProg), 0);
    Reset = 1'b0;
    tick();

    // program 1, start window, ack edge, ready timing
    launch(2'd1);
    chk("p1_startpc", int'(StartPC), 0);
    chk("p1_start_c1", int'(CpuStart), 1);
    chk("p1_busy", int'(Busy), 1);
    chk("p1_ready0", int'(ReqReady), 0);
    tick();
    chk("p1_start_c2", int'(CpuStart), 1);
    tick();
    chk("p1_start_off", int'(CpuStart), 0);
    chk("p1_busy_run", int'(Busy), 1);
    for (int i = 0; i < 8; i++) tick();
    CpuAck = 1'b1;
    expect_ev(K_DONE, 1);
    tick();
    chk("p1_fin_ready", int'(ReqReady), 0);
    chk("p1_fin_busy", int'(Busy), 0);
    tick();
    chk("p1_ready_back", int'(ReqReady), 1);

    // stale high ack must not complete program 2
    launch(2'd2);
    chk("p2_startpc", int'(StartPC), 128);
    for (int i = 0; i < 10; i++) tick();
    chk("p2_stale_busy", int'(Busy), 1);
    CpuAck = 1'b0;
    tick();
    tick();
    finish_ack(2);

    // memory mux
    HostWe = 1'b1; HostAddr = 8'd8; HostWdata = 8'h04;
    CpuWe = 1'b1; CpuAddr = 8'd3; CpuWdata = 8'h77;
    expect_ev(K_MEM, {16'd0, 8'd8, 8'h04});
    tick();
    HostWe = 1'b0; CpuWe = 1'b0;
    tick();
    launch(2'd1);
    tick();
    tick();
    HostWe = 1'b1; HostAddr = 8'd16; HostWdata = 8'h99;
    expect_ev(K_CONF, 0);
    tick();
    CpuWe = 1'b1; CpuAddr = 8'd10; CpuWdata = 8'h40;
    expect_ev(K_MEM, {16'd0, 8'd10, 8'h40});
    expect_ev(K_CONF, 0);
    tick();
    HostWe = 1'b0; CpuWe = 1'b0;
    finish_ack(1);

    // illegal request, then request ignored while running
    ReqValid = 1'b1;
    ReqProg  = 2'd0;
    expect_ev(K_ERR, 0);
    tick();
    ReqValid = 1'b0;
    chk("ill_cpustart", int'(CpuStart), 0);
    chk("ill_ready", int'(ReqReady), 1);
    chk("ill_startpc", int'(StartPC), 0);
    tick();
    launch(2'd2);
    tick();
    tick();
    ReqValid = 1'b1;
    ReqProg  = 2'd3;
    tick();
    chk("run_ready0", int'(ReqReady), 0);
    chk("run_ign_pc", int'(StartPC), 128);
    chk("run_ign_busy", int'(Busy), 1);
    ReqValid = 1'b0;
    ReqProg  = 2'd0;
    tick();
    finish_ack(2);

    // asynchronous reset in RUN
    launch(2'd3);
    tick();
    tick();
    chk("p3_startpc", int'(StartPC), 256);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_busy", int'(Busy), 0);
    chk("arst_cpustart", int'(CpuStart), 0);
    chk("arst_startpc", int'(StartPC), 0);
    chk("arst_ready", int'(ReqReady), 1);
    CpuAck = 1'b1;
    tick();
    Reset = 1'b0;
    CpuAck = 1'b0;
    tick();
    launch(2'd3);
    chk("p3b_startpc", int'(StartPC), 256);
    tick();
    tick();
    tick();
    finish_ack(3);

`ifdef WDOG_EN
    begin
      int n;
      n = 0;
      launch(2'd1);
      tick();
      tick();
      expect_ev(K_ERR, 0);
      while (Busy && n < 40) begin
        tick();
        n++;
      end
      chk("wdog_cycles", n, 16);
      chk("wdog_busy", int'(Busy), 0);
      HostWe = 1'b1; HostAddr = 8'd5; HostWdata = 8'h11;
      expect_ev(K_MEM, {16'd0, 8'd5, 8'h11});
      tick();
      HostWe = 1'b0;
    end
`endif

    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
